// File: rtl/xbar_nxn_rr.sv
// xbar_nxn_rr: N x N registered crossbar with a round-robin arbiter per output.
// Each input offers a word plus a destination index over valid/ready. Each output
// owns a one-entry register slice that can drain and refill in the same cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     [N]          input i holds a word
//   in_data      [N*DATA_W]   word of input i in slice [i*DATA_W +: DATA_W]
//   in_dest      [N*DEST_W]   target output of input i in slice [i*DEST_W +: DEST_W]
//   in_ready     [N]          combinational: input i's word accepted this cycle
//   out_valid    [N]          output j register holds a word
//   out_data     [N*DATA_W]   word held by output j
//   out_src      [N*DEST_W]   input index that supplied output j's word
//   out_ready    [N]          downstream consumes output j this cycle
module xbar_nxn_rr #(
    parameter  int unsigned N_PORTS = 4,   // power of two, >= 2
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned DEST_W  = $clog2(N_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         in_valid,
    input  logic [N_PORTS*DATA_W-1:0]  in_data,
    input  logic [N_PORTS*DEST_W-1:0]  in_dest,
    output logic [N_PORTS-1:0]         in_ready,
    output logic [N_PORTS-1:0]         out_valid,
    output logic [N_PORTS*DATA_W-1:0]  out_data,
    output logic [N_PORTS*DEST_W-1:0]  out_src,
    input  logic [N_PORTS-1:0]         out_ready
);

    // Registered per-output state
    logic [N_PORTS-1:0]  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q [N_PORTS];
    logic [DATA_W-1:0]   out_data_d [N_PORTS];
    logic [DEST_W-1:0]   out_src_q  [N_PORTS];
    logic [DEST_W-1:0]   out_src_d  [N_PORTS];
    logic [DEST_W-1:0]   rr_ptr_q   [N_PORTS];
    logic [DEST_W-1:0]   rr_ptr_d   [N_PORTS];

    // Combinational arbitration results
    logic [DATA_W-1:0]   in_word  [N_PORTS];
    logic [DEST_W-1:0]   in_tgt   [N_PORTS];
    logic [N_PORTS-1:0]  can_load;
    logic [N_PORTS-1:0]  gnt_vld;
    logic [DEST_W-1:0]   gnt_idx  [N_PORTS];

    // Unpack the flat input buses into per-input words and destinations
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            in_word[i] = in_data[i*DATA_W +: DATA_W];
            in_tgt[i]  = in_dest[i*DEST_W +: DEST_W];
        end
    end

    // Per-output round-robin: first requester scanning from rr_ptr, wrapping.
    // A full output with no downstream consumer issues no grant (back-pressure).
    always_comb begin
        logic [DEST_W-1:0] idx;
        idx = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            can_load[j] = !out_valid_q[j] || out_ready[j];
            gnt_vld[j]  = 1'b0;
            gnt_idx[j]  = '0;
            for (int unsigned k = 0; k < N_PORTS; k++) begin
                // DEST_W-bit add wraps mod N_PORTS since N_PORTS is a power of two
                idx = rr_ptr_q[j] + DEST_W'(k);
                if (!gnt_vld[j] && can_load[j] && in_valid[idx] &&
                    (in_tgt[idx] == DEST_W'(j))) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = idx;
                end
            end
        end
    end

    // An input is ready when its destination output grants it; forced low in reset
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            in_ready[i] = rst_n && gnt_vld[in_tgt[i]] &&
                          (gnt_idx[in_tgt[i]] == DEST_W'(i));
        end
    end

    // Next-state: load on grant, drain on consume, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            if (gnt_vld[j]) begin
                out_valid_d[j] = 1'b1;
                out_data_d[j]  = in_word[gnt_idx[j]];
                out_src_d[j]   = gnt_idx[j];
                rr_ptr_d[j]    = gnt_idx[j] + DEST_W'(1);
            end else if (out_ready[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                out_data_q[j] <= '0;
                out_src_q[j]  <= '0;
                rr_ptr_q[j]   <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                out_data_q[j] <= out_data_d[j];
                out_src_q[j]  <= out_src_d[j];
                rr_ptr_q[j]   <= rr_ptr_d[j];
            end
        end
    end

    // Flatten registered state onto the output buses
    always_comb begin
        out_valid = out_valid_q;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            out_data[j*DATA_W +: DATA_W] = out_data_q[j];
            out_src[j*DEST_W +: DEST_W]  = out_src_q[j];
        end
    end

endmodule

// File: tb/tb_xbar_nxn_rr.sv
// tb_xbar_nxn_rr: directed self-checking bench for the 4x4 round-robin crossbar.
module tb_xbar_nxn_rr;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_dest;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_src;
    logic [3:0]  out_ready;

    int checks = 0;
    int errors = 0;

    xbar_nxn_rr #(
        .N_PORTS (4),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;

        // Reset with all inputs requesting
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        in_dest   = {2'd1, 2'd1, 2'd1, 2'd1};
        out_ready = 4'b1111;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  out_data,       32'h0);
        check("rst_out_src",   32'(out_src),   32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        tick();
        tick();
        check("rst_hold_valid", 32'(out_valid), 32'h0);
        check("rst_hold_ready", 32'(in_ready),  32'h0);

        // Contention on output 1: grants 0,1,2,3,0 with no bubbles
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            #1;
            check($sformatf("rr_in_ready_%0d", k), 32'(in_ready), 32'(4'b0001 << g));
            tick();
            check($sformatf("rr_valid_%0d", k), 32'(out_valid),     32'h2);
            check($sformatf("rr_src_%0d", k),   32'(out_src[3:2]),  32'(g));
            check($sformatf("rr_data_%0d", k),  32'(out_data[15:8]), 32'(8'h10 + g));
        end

        // Asynchronous reset between edges, then pointer restarts at input 0
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_data",  out_data,       32'h0);
        check("arst_in_ready",  32'(in_ready),  32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_rel_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("arst_first_src",   32'(out_src[3:2]),   32'h0);
        check("arst_first_data",  32'(out_data[15:8]), 32'h10);
        check("arst_first_valid", 32'(out_valid),      32'h2);

        // Parallel permutation: inputs 0..3 to outputs 3..0
        in_valid = 4'b1111;
        in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_dest  = {2'd0, 2'd1, 2'd2, 2'd3};
        #1;
        check("perm_in_ready", 32'(in_ready), 32'hF);
        tick();
        check("perm_valid", 32'(out_valid),       32'hF);
        check("perm_data0", 32'(out_data[7:0]),   32'hA3);
        check("perm_src0",  32'(out_src[1:0]),    32'h3);
        check("perm_data1", 32'(out_data[15:8]),  32'hA2);
        check("perm_src1",  32'(out_src[3:2]),    32'h2);
        check("perm_data2", 32'(out_data[23:16]), 32'hA1);
        check("perm_src2",  32'(out_src[5:4]),    32'h1);
        check("perm_data3", 32'(out_data[31:24]), 32'hA0);
        check("perm_src3",  32'(out_src[7:6]),    32'h0);

        // Back-pressure on output 2 while input 1 requests it; others drain
        in_valid  = 4'b0010;
        in_dest   = {2'd0, 2'd0, 2'd2, 2'd0};
        in_data   = {8'hA3, 8'hA2, 8'h55, 8'hA0};
        out_ready = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(out_valid),       32'h4);
            check($sformatf("bp_data2_%0d", k), 32'(out_data[23:16]), 32'hA1);
        end
        check("drain_keeps_data0", 32'(out_data[7:0]), 32'hA3);
        out_ready = 4'b1111;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'h2);
        tick();
        check("bp_after_data2",  32'(out_data[23:16]), 32'h55);
        check("bp_after_src2",   32'(out_src[5:4]),    32'h1);
        check("bp_after_valid",  32'(out_valid),       32'h4);

        // Drain without refill: valid clears, data held
        in_valid = 4'b0000;
        #1;
        check("drain_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("drain_valid", 32'(out_valid),       32'h0);
        check("drain_data2", 32'(out_data[23:16]), 32'h55);
        check("drain_src2",  32'(out_src[5:4]),    32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
